if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller sitting directly downstream of the PC register in the IF stage. It takes the current PC, issues one instruction read at a time over a request/address-ok/data-ok SRAM-like handshake, and drives the PC register's enable so the PC only advances when its address is accepted. The fetched instruction and its PC go into a one-entry output buffer that feeds the IF/ID boundary. A branch/exception redirect flushes the buffer and discards any in-flight response.

## Interface
- WIDTH, 32, data/address width of PC and instruction
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  WIDTH  current PC (PC register output)
- pc_en  out  1  PC register load enable (combinational)
- flush  in  1  redirect this cycle; upstream next-PC mux presents the target to the PC register
- inst_req  out  1  instruction read request (combinational)
- inst_addr  out  WIDTH  request address, equals pc
- inst_addr_ok  in  1  memory accepted address this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  WIDTH  read data
- id_ready  in  1  ID stage consumes the output buffer this cycle
- if_valid  out  1  output buffer holds an instruction
- if_pc  out  WIDTH  PC of buffered instruction
- if_inst  out  WIDTH  buffered instruction

## Operation
- State machine: REQ, WAIT, DISCARD. At most one request outstanding.
- Registers: state, req_pc, if_valid, if_pc, if_inst.
- room = !if_valid || id_ready.
- REQ: inst_req = room && !flush; inst_addr = pc. On inst_req && inst_addr_ok: pc_en = 1, req_pc <= pc, go WAIT. inst_data_ok ignored in REQ.
- WAIT: inst_req = 0. On inst_data_ok: if_valid <= 1, if_pc <= req_pc, if_inst <= inst_rdata, go REQ.
- DISCARD: inst_req = 0. On inst_data_ok: data dropped, go REQ.
- flush (any state, highest priority): pc_en = 1; if_valid <= 0; no request issued. REQ stays REQ. WAIT goes DISCARD, or REQ if inst_data_ok same cycle (data dropped). DISCARD stays DISCARD unless inst_data_ok same cycle, then REQ.
- pc_en = 1 only on accepted address or flush; otherwise 0.
- Buffer pop: if_valid && id_ready && no load same cycle → if_valid <= 0. Load and pop same cycle → new contents, if_valid stays 1.
- if_pc/if_inst hold while if_valid && !id_ready; not cleared on pop or flush.

## Timing
- Reset (async): state REQ, if_valid 0, if_pc 0, if_inst 0, req_pc 0. inst_req may assert on the first clock edge after rst falls.
- Memory contract: inst_data_ok at least 1 cycle after inst_addr_ok for the same request.
- Address accepted cycle N, data_ok cycle N+k (k ≥ 1) → if_valid high from N+k+1.
- Steady state with k=1 and id_ready=1: one instruction per 2 cycles.
- inst_req may be held while inst_addr_ok=0; pc and inst_addr stable since pc_en=0.
- Reset mid-request: state returns to REQ; late inst_data_ok after reset is ignored (REQ ignores it).

## Test plan
- Reset then fetch: rst 1→0, pc=0, addr_ok same cycle, data_ok next cycle with rdata=0x24010001 → pc_en pulse at accept, if_valid=1, if_pc=0, if_inst=0x24010001 one cycle after data_ok.
- Backpressure: id_ready=0 with buffer full → inst_req=0, pc_en=0, if_pc/if_inst unchanged; raise id_ready → inst_req reasserts same cycle.
- Address stall: addr_ok low 3 cycles → inst_req held, inst_addr constant, pc_en=0; accept on 4th → single pc_en pulse.
- Flush in WAIT: accept pc=0x10, flush next cycle, data_ok 2 cycles later with 0xDEADBEEF → if_valid stays 0, pc_en=1 on flush cycle, next request only after data_ok.
- Flush and data_ok same cycle in WAIT → data dropped, state REQ next cycle, if_valid=0.
- Load and pop same cycle: buffer valid, id_ready=1, data_ok arrives → if_valid stays 1, new if_pc/if_inst.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding SRAM-like read, PC enable,
// and a one-entry buffer toward ID; a redirect flushes and drops data.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   pc / pc_en         PC register value in, load enable out
//   flush              redirect; target presented to the PC register
//   inst_req/addr      read request and address (address = pc)
//   inst_addr_ok       memory accepted the address this cycle
//   inst_data_ok/rdata read data valid and its value
//   id_ready           ID consumes the buffered instruction
//   if_valid/pc/inst   buffered instruction toward ID

module if_fetch_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             flush,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_inst_q, if_inst_d;

  logic room;
  logic load;
  logic pop;

  assign room      = !valid_q || id_ready;
  assign inst_addr = pc;
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    inst_req  = 1'b0;
    pc_en     = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;

    if (flush) begin
      // Redirect: PC takes the target, any response in flight
      // belongs to the wrong path and must be swallowed.
      pc_en   = 1'b1;
      valid_d = 1'b0;
      unique case (state_q)
        S_REQ:     state_d = S_REQ;
        S_WAIT,
        S_DISCARD: state_d = inst_data_ok ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          inst_req = room;
          if (room && inst_addr_ok) begin
            pc_en    = 1'b1;
            req_pc_d = pc;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            load    = 1'b1;
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      pop = valid_q && id_ready && !load;
      if (load) begin
        valid_d   = 1'b1;
        if_pc_d   = req_pc_q;
        if_inst_d = inst_rdata;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      req_pc_q  <= '0;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with constant expectations,
// then random traffic against a transaction-level queue model.

module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_en;
  logic        flush = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int errors = 0;
  int checks = 0;

  if_fetch_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_en        (pc_en),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] p, input logic fl,
                       input logic ao, input logic dok,
                       input logic [31:0] rd, input logic idr);
    @(negedge clk);
    pc           = p;
    flush        = fl;
    inst_addr_ok = ao;
    inst_data_ok = dok;
    inst_rdata   = rd;
    id_ready     = idr;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", if_valid);
    end
    checks++;
    if (if_pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc: got %h want 0", if_pc);
    end
    checks++;
    if (if_inst !== 32'h0) begin
      errors++; $display("FAIL rst_inst: got %h want 0", if_inst);
    end
    checks++;
    if (pc_en !== 1'b0) begin
      errors++; $display("FAIL rst_pc_en: got %b want 0", pc_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    drive(32'h0, 0, 1, 0, 32'h0, 0);
    checks++;
    if (inst_req !== 1'b1 || pc_en !== 1'b1 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL fetch_accept: got req=%b en=%b addr=%h want 1 1 0",
               inst_req, pc_en, inst_addr);
    end
    drive(32'h4, 0, 0, 1, 32'h24010001, 0);
    checks++;
    if (inst_req !== 1'b0 || pc_en !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: got req=%b en=%b v=%b want 0 0 0",
               inst_req, pc_en, if_valid);
    end
    drive(32'h4, 0, 0, 0, 32'h0, 0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h24010001)
    begin
      errors++;
      $display("FAIL fetch_out: got v=%b pc=%h inst=%h want 1 0 24010001",
               if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_backpressure;
    repeat (2) begin
      drive(32'h4, 0, 1, 0, 32'h55, 0);
      checks++;
      if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_req: got req=%b en=%b want 0 0", inst_req, pc_en);
      end
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h24010001)
      begin
        errors++;
        $display("FAIL bp_hold: got v=%b pc=%h inst=%h want 1 0 24010001",
                 if_valid, if_pc, if_inst);
      end
    end
    drive(32'h4, 0, 0, 0, 32'h0, 1);
    checks++;
    if (inst_req !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got req=%b en=%b want 1 0", inst_req, pc_en);
    end
  endtask

  task automatic test_addr_stall;
    repeat (3) begin
      drive(32'h4, 0, 0, 0, 32'h0, 1);
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h4 || pc_en !== 1'b0) begin
        errors++;
        $display("FAIL stall: got req=%b addr=%h en=%b want 1 4 0",
                 inst_req, inst_addr, pc_en);
      end
      checks++;
      if (if_valid !== 1'b0) begin
        errors++; $display("FAIL stall_pop: got v=%b want 0", if_valid);
      end
    end
    drive(32'h4, 0, 1, 0, 32'h0, 1);
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL stall_accept: got en=%b want 1", pc_en);
    end
    drive(32'h8, 0, 1, 1, 32'h0badf00d, 1);
    checks++;
    if (pc_en !== 1'b0 || inst_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_single: got en=%b req=%b want 0 0",
               pc_en, inst_req);
    end
  endtask

  task automatic test_flush_wait;
    drive(32'h10, 0, 1, 0, 32'h0, 1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h0badf00d)
    begin
      errors++;
      $display("FAIL fw_prev: got v=%b pc=%h inst=%h want 1 4 0badf00d",
               if_valid, if_pc, if_inst);
    end
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL fw_accept: got en=%b want 1", pc_en);
    end
    drive(32'h14, 1, 1, 0, 32'h0, 1);
    checks++;
    if (pc_en !== 1'b1 || inst_req !== 1'b0) begin
      errors++;
      $display("FAIL fw_flush: got en=%b req=%b want 1 0", pc_en, inst_req);
    end
    drive(32'h40, 0, 1, 0, 32'h0, 1);
    checks++;
    if (inst_req !== 1'b0 || pc_en !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fw_discard: got req=%b en=%b v=%b want 0 0 0",
               inst_req, pc_en, if_valid);
    end
    drive(32'h40, 0, 1, 1, 32'hdeadbeef, 1);
    checks++;
    if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL fw_drop: got req=%b en=%b want 0 0", inst_req, pc_en);
    end
    drive(32'h40, 0, 0, 0, 32'h0, 1);
    checks++;
    if (if_valid !== 1'b0 || inst_req !== 1'b1) begin
      errors++;
      $display("FAIL fw_after: got v=%b req=%b want 0 1", if_valid, inst_req);
    end
  endtask

  task automatic test_flush_data_same;
    drive(32'h40, 0, 1, 0, 32'h0, 1);
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL fd_accept: got en=%b want 1", pc_en);
    end
    drive(32'h44, 1, 0, 1, 32'h11111111, 1);
    checks++;
    if (pc_en !== 1'b1 || inst_req !== 1'b0) begin
      errors++;
      $display("FAIL fd_flush: got en=%b req=%b want 1 0", pc_en, inst_req);
    end
    drive(32'h80, 0, 0, 0, 32'h0, 1);
    checks++;
    if (if_valid !== 1'b0 || inst_req !== 1'b1) begin
      errors++;
      $display("FAIL fd_after: got v=%b req=%b want 0 1", if_valid, inst_req);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p;
    for (int i = 0; i < 4; i++) begin
      p = 32'h100 + 32'(4 * i);
      drive(p, 0, 1, 0, 32'h0, 1);
      checks++;
      if (pc_en !== 1'b1 || inst_req !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept%0d: got en=%b req=%b want 1 1",
                 i, pc_en, inst_req);
      end
      if (i > 0) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== p - 32'h4 ||
            if_inst !== 32'ha0000000 + 32'(i - 1)) begin
          errors++;
          $display("FAIL b2b_out%0d: got v=%b pc=%h inst=%h want 1 %h %h",
                   i, if_valid, if_pc, if_inst, p - 32'h4,
                   32'ha0000000 + 32'(i - 1));
        end
      end
      drive(p + 32'h4, 0, 0, 1, 32'ha0000000 + 32'(i), 1);
      checks++;
      if (if_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_pop%0d: got v=%b want 0", i, if_valid);
      end
    end
    drive(32'h110, 0, 0, 0, 32'h0, 0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10c || if_inst !== 32'ha0000003)
    begin
      errors++;
      $display("FAIL b2b_last: got v=%b pc=%h inst=%h want 1 10c a0000003",
               if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_reset_mid;
    drive(32'h200, 0, 1, 0, 32'h0, 1);
    checks++;
    if (pc_en !== 1'b1) begin
      errors++; $display("FAIL rm_accept: got en=%b want 1", pc_en);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL rm_async: got v=%b pc=%h inst=%h want 0 0 0",
               if_valid, if_pc, if_inst);
    end
    drive(32'h200, 0, 0, 0, 32'h0, 1);
    rst = 1'b0;
    drive(32'h200, 0, 0, 1, 32'h77, 1);
    checks++;
    if (inst_req !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL rm_late: got req=%b en=%b want 1 0", inst_req, pc_en);
    end
    drive(32'h200, 0, 0, 0, 32'h0, 1);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL rm_ignored: got v=%b want 0", if_valid);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          keep;
  } pend_t;

  task automatic test_random;
    pend_t       pend[$];
    pend_t       p;
    int          buf_n;
    logic [31:0] last_pc, last_inst, mpc, tgt, rd;
    int          mem_wait;
    logic        fl, ao, dok, idr, room, ereq, acc, een, got;

    rst = 1'b1;
    drive(32'h0, 0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    buf_n = 0; last_pc = '0; last_inst = '0; mpc = '0; mem_wait = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      fl  = ($urandom_range(0, 9) == 0);
      ao  = 1'($urandom_range(0, 1));
      idr = ($urandom_range(0, 3) != 0);
      rd  = $urandom;
      tgt = $urandom & 32'hfffffffc;
      dok = 1'b0;
      if (pend.size() > 0) begin
        if (mem_wait == 0) dok = 1'b1;
        else mem_wait--;
      end
      drive(mpc, fl, ao, dok, rd, idr);

      room = (buf_n == 0) || idr;
      ereq = (pend.size() == 0) && room && !fl;
      acc  = ereq && ao;
      een  = acc || fl;

      checks++;
      if (inst_req !== ereq || pc_en !== een || inst_addr !== mpc) begin
        errors++;
        $display("FAIL rnd_req c%0d: got req=%b en=%b addr=%h want %b %b %h",
                 cyc, inst_req, pc_en, inst_addr, ereq, een, mpc);
      end
      checks++;
      if (if_valid !== (buf_n > 0) || if_pc !== last_pc ||
          if_inst !== last_inst) begin
        errors++;
        $display("FAIL rnd_buf c%0d: got v=%b pc=%h inst=%h want %b %h %h",
                 cyc, if_valid, if_pc, if_inst, (buf_n > 0),
                 last_pc, last_inst);
      end

      got = 1'b0;
      if (dok && pend.size() > 0) begin
        p   = pend.pop_front();
        got = p.keep && !fl;
      end
      if (fl) begin
        if (pend.size() > 0) pend[0].keep = 1'b0;
        buf_n = 0;
      end else begin
        if (buf_n > 0 && idr) buf_n = 0;
        if (got) begin
          buf_n     = 1;
          last_pc   = p.pc;
          last_inst = rd;
        end
      end
      if (acc) begin
        pend.push_back('{pc: mpc, keep: 1'b1});
        mem_wait = $urandom_range(0, 2);
      end
      if (fl) mpc = tgt;
      else if (acc) mpc = mpc + 32'h4;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_addr_stall();
    test_flush_wait();
    test_flush_data_same();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
